// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared types for the instruction/data memory bus arbiter:
//   - arb_state_e : arbiter FSM state encoding (3-bit)
//   - BUS_SZ_*    : bus transfer size codes (byte / half / word)
//   - bus_cmd_t   : request fields latched at grant time and replayed on the bus
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } arb_state_e;

    localparam logic [1:0] BUS_SZ_B = 2'd0;
    localparam logic [1:0] BUS_SZ_H = 2'd1;
    localparam logic [1:0] BUS_SZ_W = 2'd2;

    // Address is kept outside the struct because its width is a parameter.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_cmd_t;

    // Fetches are always word reads with no byte enables.
    function automatic bus_cmd_t inst_cmd();
        bus_cmd_t c;
        c.wr    = 1'b0;
        c.size  = BUS_SZ_W;
        c.wstrb = 4'b0000;
        c.wdata = 32'h0;
        return c;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_2to1.sv
// ---------------------------------------------------------------------------
// arb_2to1
// Purely combinational two-way arbiter.
//   req0, req1 : request lines (req0 = fetch, req1 = data in this design)
//   last       : 1 if req1 won the previous arbitration
//   fixed_pri  : 1 -> req1 always wins a tie; 0 -> tie goes opposite 'last'
//   gnt0, gnt1 : one-hot (or zero) grant
// ---------------------------------------------------------------------------
module arb_2to1 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic fixed_pri,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves it unassigned and no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (fixed_pri || !last) gnt1 = 1'b1;
            else                    gnt0 = 1'b1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like bus between the fetch port (inst_*) and the load/store
// port (data_*). One transaction outstanding at a time: grant in IDLE, latch
// the request, run the address phase, wait for the data phase, return rdata.
//
// Parameters
//   DATA_FIRST : 1 = data port wins ties; 0 = round-robin on last grant
//   ADDR_WD    : address width
// Ports
//   clk, reset (sync, active-high), flush (abort / discard in-flight work)
//   inst_req/inst_addr            -> inst_addr_ok, inst_data_ok, inst_rdata
//   data_req/wr/size/wstrb/addr/wdata -> data_addr_ok, data_data_ok, data_rdata
//   bus_req/wr/size/wstrb/addr/wdata  -> bridge; bus_addr_ok/data_ok/rdata <- bridge
//   stallreq_axi : pipeline hold (transaction in flight or data request pending)
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1,
    parameter int ADDR_WD    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,

    input  logic               inst_req,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [31:0]        inst_rdata,

    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [3:0]         data_wstrb,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,

    output logic               bus_req,
    output logic               bus_wr,
    output logic [1:0]         bus_size,
    output logic [3:0]         bus_wstrb,
    output logic [ADDR_WD-1:0] bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [31:0]        bus_rdata,

    output logic               stallreq_axi
);

    arb_state_e         state_q, state_d;
    logic               drop_q, drop_d;           // discard the pending response
    logic               last_data_q, last_data_d; // 1: data port won last grant
    bus_cmd_t           cmd_q, cmd_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [31:0]        inst_rdata_q, data_rdata_q;
    logic               gnt_inst, gnt_data;

    arb_2to1 u_arb (
        .req0      (inst_req),
        .req1      (data_req),
        .last      (last_data_q),
        .fixed_pri (DATA_FIRST),
        .gnt0      (gnt_inst),
        .gnt1      (gnt_data)
    );

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        last_data_d  = last_data_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        bus_req      = 1'b0;

        // Under reset nothing is accepted or reported; the register block
        // forces IDLE on the same edge.
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    drop_d = 1'b0;
                    if (!flush) begin
                        if (gnt_data) begin
                            data_addr_ok = 1'b1;
                            cmd_d.wr     = data_wr;
                            cmd_d.size   = data_size;
                            cmd_d.wstrb  = data_wstrb;
                            cmd_d.wdata  = data_wdata;
                            addr_d       = data_addr;
                            last_data_d  = 1'b1;
                            state_d      = ST_D_ADDR;
                        end else if (gnt_inst) begin
                            inst_addr_ok = 1'b1;
                            cmd_d        = inst_cmd();
                            addr_d       = inst_addr;
                            last_data_d  = 1'b0;
                            state_d      = ST_I_ADDR;
                        end
                    end
                end

                ST_I_ADDR, ST_D_ADDR: begin
                    bus_req = 1'b1;
                    if (bus_addr_ok) begin
                        // Address accepted: the bridge owes us a response, so
                        // a flush can only discard it, never cancel it.
                        state_d = (state_q == ST_D_ADDR) ? ST_D_DATA : ST_I_DATA;
                        if (flush) drop_d = 1'b1;
                    end else if (flush) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_I_DATA, ST_D_DATA: begin
                    if (flush) drop_d = 1'b1;
                    if (bus_data_ok) begin
                        state_d = ST_IDLE;
                        // A flush arriving with the response discards it too.
                        if (!drop_q && !flush) begin
                            if (state_q == ST_D_DATA) data_data_ok = 1'b1;
                            else                      inst_data_ok = 1'b1;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= ST_IDLE;
            drop_q       <= 1'b0;
            last_data_q  <= 1'b0;
            cmd_q        <= '0;
            addr_q       <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            last_data_q <= last_data_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            if (inst_data_ok) inst_rdata_q <= bus_rdata;
            if (data_data_ok) data_rdata_q <= bus_rdata;
        end
    end

    // Bus fields come straight from the latched request, so they stay stable
    // for the whole address phase even if the requester changes its inputs.
    assign bus_wr    = cmd_q.wr;
    assign bus_size  = cmd_q.size;
    assign bus_wstrb = cmd_q.wstrb;
    assign bus_wdata = cmd_q.wdata;
    assign bus_addr  = addr_q;

    // Read data is forwarded in the pulse cycle, then held until the next one.
    assign inst_rdata = inst_data_ok ? bus_rdata : inst_rdata_q;
    assign data_rdata = data_data_ok ? bus_rdata : data_rdata_q;

    // A lone fetch in IDLE does not stall; the fetch stage waits on its own.
    assign stallreq_axi = (state_q != ST_IDLE) | data_req;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench. Two arbiters share all inputs: 'dut' (data-first) carries
// the scenario tests, 'dut_rr' (round-robin) is checked in the grant-order
// test after a common reset. Inputs change 1 ns after posedge, outputs are
// sampled 2 ns after posedge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr, stallreq_axi;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;

    logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
    logic [31:0] rr_inst_rdata, rr_data_rdata;
    logic        rr_bus_req, rr_bus_wr, rr_stallreq_axi;
    logic [1:0]  rr_bus_size;
    logic [3:0]  rr_bus_wstrb;
    logic [31:0] rr_bus_addr, rr_bus_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DATA_FIRST(1'b1), .ADDR_WD(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_axi(stallreq_axi)
    );

    mem_bus_arbiter #(.DATA_FIRST(1'b0), .ADDR_WD(32)) dut_rr (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
        .bus_req(rr_bus_req), .bus_wr(rr_bus_wr), .bus_size(rr_bus_size), .bus_wstrb(rr_bus_wstrb),
        .bus_addr(rr_bus_addr), .bus_wdata(rr_bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq_axi(rr_stallreq_axi)
    );

    task automatic idle_inputs();
        flush = 0; inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    // Advance to 1 ns after the next rising edge (input-drive point).
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("FAIL reset_handshakes: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", inst_rdata, data_rdata); end
        checks++; if (stallreq_axi !== 1'b0 || rr_stallreq_axi !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b/%b want 0/0", stallreq_axi, rr_stallreq_axi); end
    endtask

    task automatic test_solo_load();
        cyc(); data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1c000010; #1;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL load_addr_ok: got d=%b i=%b want d=1 i=0", data_addr_ok, inst_addr_ok); end
        checks++; if (stallreq_axi !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL load_c0: got stall=%b bus_req=%b want 1/0", stallreq_axi, bus_req); end
        cyc(); data_req = 0; #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1c000010 || bus_wr !== 1'b0) begin errors++; $display("FAIL load_bus_c1: got req=%b addr=%h wr=%b want 1/1c000010/0", bus_req, bus_addr, bus_wr); end
        checks++; if (stallreq_axi !== 1'b1) begin errors++; $display("FAIL load_stall_c1: got %b want 1", stallreq_axi); end
        cyc(); bus_addr_ok = 1; #1;
        checks++; if (bus_req !== 1'b1 || stallreq_axi !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL load_c2: got req=%b stall=%b dok=%b want 1/1/0", bus_req, stallreq_axi, data_data_ok); end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hdeadbeef; #1;
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL load_data_ok: got ok=%b rdata=%h want 1/deadbeef", data_data_ok, data_rdata); end
        checks++; if (bus_req !== 1'b0 || stallreq_axi !== 1'b1) begin errors++; $display("FAIL load_c3: got req=%b stall=%b want 0/1", bus_req, stallreq_axi); end
        cyc(); bus_data_ok = 0; bus_rdata = '0; #1;
        checks++; if (data_data_ok !== 1'b0 || data_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL load_hold: got ok=%b rdata=%h want 0/deadbeef", data_data_ok, data_rdata); end
        checks++; if (stallreq_axi !== 1'b0) begin errors++; $display("FAIL load_stall_idle: got %b want 0", stallreq_axi); end
    endtask

    task automatic test_contention();
        cyc(); inst_req = 1; inst_addr = 32'h1c000100; data_req = 1; data_addr = 32'h1c000200; #1;
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL cont_first: got d=%b i=%b want 1/0", data_addr_ok, inst_addr_ok); end
        cyc(); data_req = 0; bus_addr_ok = 1; #1;
        checks++; if (bus_addr !== 32'h1c000200 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL cont_daddr: got addr=%h iok=%b want 1c000200/0", bus_addr, inst_addr_ok); end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11112222; #1;
        checks++; if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL cont_ddata: got dok=%b iok=%b want 1/0", data_data_ok, inst_addr_ok); end
        cyc(); bus_data_ok = 0; bus_rdata = '0; #1;
        checks++; if (inst_addr_ok !== 1'b1 || stallreq_axi !== 1'b0) begin errors++; $display("FAIL cont_inst_grant: got iok=%b stall=%b want 1/0", inst_addr_ok, stallreq_axi); end
        cyc(); inst_req = 0; bus_addr_ok = 1; #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1c000100 || bus_size !== 2'd2 || bus_wr !== 1'b0) begin errors++; $display("FAIL cont_ibus: got req=%b addr=%h size=%0d wr=%b want 1/1c000100/2/0", bus_req, bus_addr, bus_size, bus_wr); end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0badf00d; #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0badf00d || data_data_ok !== 1'b0) begin errors++; $display("FAIL cont_idata: got iok=%b rdata=%h dok=%b want 1/0badf00d/0", inst_data_ok, inst_rdata, data_data_ok); end
        cyc(); bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_flush_before_addr_ok();
        data_req = 1; data_addr = 32'h1c000300; flush = 1; #1;
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL flush_idle_no_grant: got %b want 0", data_addr_ok); end
        cyc(); flush = 0; #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL fa_grant: got %b want 1", data_addr_ok); end
        cyc(); data_req = 0; flush = 1; #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fa_bus_req: got %b want 1", bus_req); end
        cyc(); flush = 0; #1;
        checks++; if (bus_req !== 1'b0 || stallreq_axi !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL fa_abort: got req=%b stall=%b dok=%b want 0/0/0", bus_req, stallreq_axi, data_data_ok); end
        for (int i = 0; i < 3; i++) begin
            cyc(); bus_data_ok = 1; bus_rdata = 32'hffffffff; #1;
            checks++; if (data_data_ok !== 1'b0 || data_rdata !== 32'h11112222) begin errors++; $display("FAIL fa_stray_data_ok[%0d]: got ok=%b rdata=%h want 0/11112222", i, data_data_ok, data_rdata); end
        end
        cyc(); bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_flush_after_addr_ok();
        inst_req = 1; inst_addr = 32'h1c000400; #1;
        checks++; if (inst_addr_ok !== 1'b1 || stallreq_axi !== 1'b0) begin errors++; $display("FAIL fd_grant: got iok=%b stall=%b want 1/0", inst_addr_ok, stallreq_axi); end
        cyc(); inst_req = 0; bus_addr_ok = 1; #1;
        checks++; if (bus_req !== 1'b1 || stallreq_axi !== 1'b1) begin errors++; $display("FAIL fd_addr: got req=%b stall=%b want 1/1", bus_req, stallreq_axi); end
        cyc(); bus_addr_ok = 0; flush = 1; #1;
        checks++; if (bus_req !== 1'b0 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL fd_flush: got req=%b iok=%b want 0/0", bus_req, inst_data_ok); end
        cyc(); flush = 0; #1;
        checks++; if (stallreq_axi !== 1'b1) begin errors++; $display("FAIL fd_wait_stall: got %b want 1", stallreq_axi); end
        cyc(); bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
        checks++; if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0badf00d) begin errors++; $display("FAIL fd_dropped: got ok=%b rdata=%h want 0/0badf00d", inst_data_ok, inst_rdata); end
        cyc(); bus_data_ok = 0; bus_rdata = '0; #1;
        checks++; if (stallreq_axi !== 1'b0 || inst_rdata !== 32'h0badf00d) begin errors++; $display("FAIL fd_after: got stall=%b rdata=%h want 0/0badf00d", stallreq_axi, inst_rdata); end
        cyc(); inst_req = 1; inst_addr = 32'h1c000404; #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL fd_next_grant: got %b want 1", inst_addr_ok); end
        cyc(); inst_req = 0; bus_addr_ok = 1; #1;
        checks++; if (bus_addr !== 32'h1c000404) begin errors++; $display("FAIL fd_next_addr: got %h want 1c000404", bus_addr); end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hcafef00d; #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hcafef00d) begin errors++; $display("FAIL fd_next_data: got ok=%b rdata=%h want 1/cafef00d", inst_data_ok, inst_rdata); end
        cyc(); bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_store();
        logic [71:0] want_bus;
        want_bus = {1'b1, 1'b1, 2'd0, 4'b0100, 32'h1c000020, 32'h00aa0000};
        data_req = 1; data_wr = 1; data_size = 2'd0; data_wstrb = 4'b0100;
        data_addr = 32'h1c000020; data_wdata = 32'h00aa0000; #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL st_grant: got %b want 1", data_addr_ok); end
        for (int i = 0; i < 5; i++) begin
            cyc(); data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
            data_addr = 32'h0; data_wdata = 32'hffffffff; #1;
            checks++; if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== want_bus) begin errors++; $display("FAIL st_bus_hold[%0d]: got %h want %h", i, {bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, want_bus); end
        end
        cyc(); bus_addr_ok = 1; #1;
        checks++; if (bus_req !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL st_accept: got req=%b dok=%b want 1/0", bus_req, data_data_ok); end
        cyc(); bus_addr_ok = 0; bus_data_ok = 1; #1;
        checks++; if (data_data_ok !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL st_resp: got dok=%b req=%b want 1/0", data_data_ok, bus_req); end
        cyc(); bus_data_ok = 0; #1;
        checks++; if (data_data_ok !== 1'b0 || stallreq_axi !== 1'b0) begin errors++; $display("FAIL st_idle: got dok=%b stall=%b want 0/0", data_data_ok, stallreq_axi); end
    endtask

    task automatic test_reset_mid();
        cyc(); data_req = 1; data_wr = 0; data_addr = 32'h1c000500; #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rm_grant: got %b want 1", data_addr_ok); end
        cyc(); data_req = 0; #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_addr: got %b want 1", bus_req); end
        cyc(); reset = 1;
        cyc(); reset = 0; bus_addr_ok = 1; #1;
        checks++; if (bus_req !== 1'b0 || stallreq_axi !== 1'b0 || data_rdata !== 32'h0) begin errors++; $display("FAIL rm_idle: got req=%b stall=%b rdata=%h want 0/0/0", bus_req, stallreq_axi, data_rdata); end
        cyc(); bus_addr_ok = 0; #1;
        checks++; if (bus_req !== 1'b0 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL rm_quiet: got req=%b dok=%b want 0/0", bus_req, data_addr_ok); end
    endtask

    // Both ports held high, bus answers immediately: a grant every 3 cycles.
    // Bit k of each sequence is 1 when grant k went to the data port.
    task automatic test_round_robin();
        logic [3:0] fx_seq, rr_seq;
        int         fx_n, rr_n;
        fx_seq = '0; rr_seq = '0; fx_n = 0; rr_n = 0;
        cyc(); inst_req = 1; inst_addr = 32'h1c000600; data_req = 1; data_addr = 32'h1c000700;
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5a5a5a5a;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (data_addr_ok || inst_addr_ok) begin
                if (fx_n < 4) fx_seq[fx_n] = data_addr_ok;
                fx_n++;
            end
            if (rr_data_addr_ok || rr_inst_addr_ok) begin
                if (rr_n < 4) rr_seq[rr_n] = rr_data_addr_ok;
                rr_n++;
            end
            cyc();
        end
        idle_inputs();
        checks++; if (rr_n !== 4 || rr_seq !== 4'b0101) begin errors++; $display("FAIL rr_order: got n=%0d seq=%b want n=4 seq=0101 (D,I,D,I)", rr_n, rr_seq); end
        checks++; if (fx_n !== 4 || fx_seq !== 4'b1111) begin errors++; $display("FAIL fixed_order: got n=%0d seq=%b want n=4 seq=1111", fx_n, fx_seq); end
    endtask

    initial begin
        test_reset();
        test_solo_load();
        test_contention();
        test_flush_before_addr_ok();
        test_flush_after_addr_ok();
        test_store();
        test_reset_mid();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
